ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse.
//  Generates the inhibit / request-to-send sequence, shifts bits on device-generated clock, checks the device ACK.
//  Shares the PS2_CLK/PS2_DAT open-drain lines with the PS/2 receiver; the receiver must be held off while tx_busy=1.
// PARAMETERS
//  INHIBIT_CYCLES  6000       clk cycles CLK held low before request-to-send (120 us @ 50 MHz)
//  TIMEOUT_CYCLES  1_000_000  max clk cycles from CLK release to bus idle (20 ms @ 50 MHz)
// PORTS
//  clk        in    1  system clock (50 MHz)
//  reset      in    1  asynchronous, active-high reset
//  tx_data    in    8  command byte; sampled on accepted tx_start
//  tx_start   in    1  one-cycle request; accepted only when tx_busy=0
//  tx_busy    out   1  high from cycle after accept until transfer ends
//  tx_done    out   1  one-cycle pulse: byte sent and ACK received
//  tx_error   out   1  one-cycle pulse: timeout or NACK
//  PS2_CLK    inout 1  open-drain: driven 1'b0 or 1'bz, never 1'b1
//  PS2_DAT    inout 1  open-drain: driven 1'b0 or 1'bz, never 1'b1
// BEHAVIOUR
//  - Reset (async): state IDLE, both lines 1'bz, tx_busy/tx_done/tx_error 0, shift reg/counters 0.
//  - PS2_CLK/PS2_DAT inputs pass through a 2-FF synchronizer; fall = prev_sync 1 & sync 0 (2-3 clk latency).
//  - Frame: start(0), d[0]..d[7] LSB first, odd parity (XOR of d inverted), stop(1 = release), device ACK(0).
//  - States / transitions:
//    IDLE    : lines z; tx_start -> latch {parity,tx_data}, bit_cnt=0, -> INHIBIT.
//    INHIBIT : CLK driven 0; after INHIBIT_CYCLES also drive DAT 0 (start bit); next cycle -> RTS.
//    RTS     : release CLK (z), keep DAT 0, clear timeout counter; fall -> DATA, drive d[0].
//    DATA    : each fall: bit_cnt++, drive next bit (0 -> drive 0, 1 -> z); after d[7] the
//              next fall drives parity -> PARITY.
//    PARITY  : fall -> release DAT (stop bit) -> STOP.
//    STOP    : fall -> sample DAT: 0 = ACK -> WAIT_IDLE; 1 = NACK -> ERR.
//    WAIT_IDLE: wait sync CLK=1 and DAT=1 -> IDLE with tx_done=1 that cycle.
//    ERR     : release both lines, tx_error=1 for one cycle -> IDLE.
//  - Timeout: counter runs in RTS..WAIT_IDLE; reaching TIMEOUT_CYCLES -> ERR (lines released immediately).
//  - tx_busy = (state != IDLE). Done/error pulse coincides with first IDLE cycle; tx_start in
//    that cycle is accepted (back-to-back commands).
//  - tx_start while busy: ignored, tx_data not re-latched.
//  - tx_done and tx_error never assert together; exactly one per accepted start.
//  - Reset mid-transfer: lines released asynchronously, no done/error pulse.
//  - Data bits are changed only on synchronized falls of PS2_CLK (device samples on rising edge).
// TESTING
//  1 tx_data=0xF4 start; device model clocks 12.5 kHz, ACKs -> DAT bits 0,0,0,1,0,1,1,1,1, parity 0; tx_done once.
//  2 tx_data=0xFF -> parity 1; 0x00 -> parity 1; both end with tx_done, busy low after.
//  3 CLK held low >= INHIBIT_CYCLES before DAT falls; DAT low before CLK released (measure in clk cycles).
//  4 Device never clocks -> tx_error pulse exactly TIMEOUT_CYCLES after CLK release; both lines z.
//  5 Device leaves DAT high at ACK edge -> tx_error, no tx_done; tx_start mid-frame with 0x12 ignored.
//  6 Assert reset during DATA bit 4 -> both lines z immediately; next start 0xF4 completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts one
// command byte out on the device-generated clock and checks the device ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DAT
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES);
   // ERR and the pulse cycle take one clk each, so the error pulse lands exactly
   // TIMEOUT_CYCLES after CLK is released.
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE, S_ERR
   } state_t;

   state_t           state, state_n;
   logic [1:0]       clk_sync, dat_sync;
   logic             clk_prev;
   logic [8:0]       shift_reg;
   logic [2:0]       bit_cnt;
   logic [INH_W-1:0] inh_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic             clk_low, dat_low;
   logic             fall, inh_done, timeout, timed;

   assign fall     = clk_prev & ~clk_sync[1];
   assign inh_done = (inh_cnt == INH_LAST);
   assign timed    = (state == S_RTS) || (state == S_DATA) || (state == S_PARITY) ||
                     (state == S_STOP) || (state == S_WAIT_IDLE);
   assign timeout  = timed && (to_cnt == TO_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // NOTE: every always_comb output gets a default first; a path that leaves one
   // unassigned would infer a latch.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:      if (tx_start) state_n = S_INHIBIT;
         S_INHIBIT:   if (inh_done) state_n = S_RTS;
         S_RTS:       if (timeout) state_n = S_ERR;
                      else if (fall) state_n = S_DATA;
         S_DATA:      if (timeout) state_n = S_ERR;
                      else if (fall && bit_cnt == 3'd7) state_n = S_PARITY;
         S_PARITY:    if (timeout) state_n = S_ERR;
                      else if (fall) state_n = S_STOP;
         S_STOP:      if (timeout) state_n = S_ERR;
                      else if (fall) state_n = dat_sync[1] ? S_ERR : S_WAIT_IDLE;
         S_WAIT_IDLE: if (timeout) state_n = S_ERR;
                      else if (clk_sync[1] && dat_sync[1]) state_n = S_IDLE;
         S_ERR:       state_n = S_IDLE;
         default:     state_n = S_IDLE;
      endcase
   end

   always_comb begin
      clk_low = 1'b0;
      dat_low = 1'b0;
      tx_busy = (state != S_IDLE);
      case (state)
         S_INHIBIT: begin
            clk_low = 1'b1;
            dat_low = inh_done;
         end
         S_RTS:              dat_low = 1'b1;
         S_DATA, S_PARITY:   dat_low = ~shift_reg[0];
         default: ;
      endcase
   end

   // Open-drain: only ever pull low or float.
   assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
   assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

   // NOTE: all datapath registers are reset, not only control; the synchronizers
   // reset to the idle-high bus level so no false fall appears after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         dat_sync  <= 2'b11;
         clk_prev  <= 1'b1;
         shift_reg <= '0;
         bit_cnt   <= '0;
         inh_cnt   <= '0;
         to_cnt    <= '0;
         tx_done   <= 1'b0;
         tx_error  <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], PS2_CLK};
         dat_sync <= {dat_sync[0], PS2_DAT};
         clk_prev <= clk_sync[1];

         if (state == S_IDLE && tx_start) begin
            shift_reg <= {~^tx_data, tx_data};
            bit_cnt   <= '0;
         end else if (state == S_DATA && fall) begin
            shift_reg <= {1'b0, shift_reg[8:1]};
            bit_cnt   <= bit_cnt + 3'd1;
         end

         if (state != S_INHIBIT) inh_cnt <= '0;
         else if (!inh_done)     inh_cnt <= inh_cnt + INH_W'(1);

         to_cnt <= timed ? to_cnt + TO_W'(1) : '0;

         tx_done  <= (state == S_WAIT_IDLE) && (state_n == S_IDLE);
         tx_error <= (state == S_ERR);
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of
// the host and the captured bits are compared against a frame built from the byte.
module tb_ps2_host_tx;

   localparam int INH = 50;
   localparam int TO  = 1500;
   localparam int HP  = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   wire        tx_busy, tx_done, tx_error;
   wire        ps2_clk, ps2_dat;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;
   int n_err   = 0;
   int n_both  = 0;
   int expected_pulses = 0;

   assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
   assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
   pullup (ps2_clk);
   pullup (ps2_dat);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .tx_error (tx_error),
      .PS2_CLK  (ps2_clk),
      .PS2_DAT  (ps2_dat)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_done === 1'b1)                       n_done <= n_done + 1;
      if (tx_error === 1'b1)                      n_err  <= n_err + 1;
      if (tx_done === 1'b1 && tx_error === 1'b1)  n_both <= n_both + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_cmd(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      check("busy_after_start", tx_busy, 1);
   endtask

   // Returns at the first sample where CLK is seen released after being held low.
   task automatic watch_request(output int c_clk, output int c_dat, output int c_rel, output bit ok);
      c_clk = -1; c_dat = -1; c_rel = -1; ok = 1'b0;
      for (int i = 0; i < INH * 4 + 40; i++) begin
         if (ps2_clk === 1'b0 && c_clk < 0) c_clk = i;
         if (ps2_dat === 1'b0 && c_dat < 0) c_dat = i;
         if (ps2_clk === 1'b1 && c_clk >= 0) begin
            c_rel = i;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Device: n_falls clock pulses, samples DAT on each rising edge, ACKs after the stop bit.
   task automatic device_xfer(input int n_falls, input bit ack, output logic [9:0] bits);
      bits = '0;
      repeat (HP) @(negedge clk);
      for (int i = 1; i <= n_falls; i++) begin
         dev_clk_low = 1'b1;
         repeat (HP) @(negedge clk);
         dev_clk_low = 1'b0;
         #1;
         if (i <= 10) bits[i-1] = ps2_dat;
         if (i == 10 && ack) dev_dat_low = 1'b1;
         if (i == 11) dev_dat_low = 1'b0;
         repeat (HP) @(negedge clk);
      end
      dev_dat_low = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (tx_busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_xfer(input logic [7:0] d, input bit ack, input bit inject);
      int c_clk, c_dat, c_rel, d0, e0;
      bit ok;
      logic [9:0] bits, exp_frame;
      d0 = n_done;
      e0 = n_err;
      start_cmd(d);
      watch_request(c_clk, c_dat, c_rel, ok);
      check("rts_seen", ok, 1);
      check("inhibit_len", (c_dat - c_clk >= INH), 1);
      check("dat_before_release", (c_dat >= 0 && c_dat < c_rel), 1);
      check("start_bit", ps2_dat, 0);
      fork
         device_xfer(11, ack, bits);
         if (inject) begin
            repeat (150) @(negedge clk);
            tx_data  = 8'h12;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
         end
      join
      exp_frame = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d};
      check("frame", bits, exp_frame);
      wait_idle(ok);
      check("idle_reached", ok, 1);
      repeat (5) @(negedge clk);
      check("done_count", n_done - d0, ack ? 1 : 0);
      check("err_count", n_err - e0, ack ? 0 : 1);
      check("busy_low_after", tx_busy, 0);
      check("clk_idle_after", ps2_clk, 1);
      expected_pulses++;
   endtask

   task automatic timeout_test();
      int c_clk, c_dat, c_rel, d0, e0, lat;
      bit ok;
      d0 = n_done;
      e0 = n_err;
      lat = -1;
      start_cmd(8'hF4);
      watch_request(c_clk, c_dat, c_rel, ok);
      check("to_rts_seen", ok, 1);
      for (int j = 1; j <= TO + 50; j++) begin
         @(negedge clk);
         if (tx_error === 1'b1) begin
            lat = j;
            break;
         end
      end
      check("timeout_latency", lat, TO);
      check("to_clk_released", ps2_clk, 1);
      check("to_dat_released", ps2_dat, 1);
      repeat (5) @(negedge clk);
      check("to_err_count", n_err - e0, 1);
      check("to_done_count", n_done - d0, 0);
      expected_pulses++;
   endtask

   task automatic reset_test();
      int c_clk, c_dat, c_rel, d0, e0;
      bit ok;
      logic [7:0] d;
      logic [9:0] bits;
      d = 8'($urandom) & 8'hEF;
      start_cmd(d);
      watch_request(c_clk, c_dat, c_rel, ok);
      check("rst_rts_seen", ok, 1);
      device_xfer(5, 1'b0, bits);
      check("rst_partial_bits", bits[4:0], d[4:0]);
      check("rst_bit4_driven", ps2_dat, 0);
      d0 = n_done;
      e0 = n_err;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_clk_released", ps2_clk, 1);
      check("rst_dat_released", ps2_dat, 1);
      check("rst_busy_low", tx_busy, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_no_done", n_done - d0, 0);
      check("rst_no_err", n_err - e0, 0);
   endtask

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_busy", tx_busy, 0);
      check("reset_done", tx_done, 0);
      check("reset_error", tx_error, 0);
      check("reset_clk_z", ps2_clk, 1);
      check("reset_dat_z", ps2_dat, 1);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      do_xfer(8'hF4, 1'b1, 1'b0);
      do_xfer(8'hFF, 1'b1, 1'b0);
      do_xfer(8'h00, 1'b1, 1'b0);
      timeout_test();
      do_xfer(8'($urandom), 1'b0, 1'b1);
      reset_test();
      do_xfer(8'hF4, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         do_xfer(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      end

      repeat (3) @(negedge clk);
      check("never_both", n_both, 0);
      check("pulses_total", n_done + n_err, expected_pulses);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
